spi_reg_bridge: RTL and testbench

Command decoder and register bank downstream of the SPI slave, in the system clock domain. It consumes each received word (`rx_data`/`rx_strobe`), interprets consecutive frames as command/data pairs, and drives the word the slave shifts out in the next frame (`tx_data`). It exposes NREG read/write control registers and NREG read-only status registers to the rest of the design.

---
 rtl/spi_reg_bridge.sv | 152 +++++++++++++++
 tb/tb_spi_reg_bridge.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: turns pairs of SPI frames (command, data) into register
// reads and writes. It holds NREG control registers and exposes NREG
// read-only status words. tx_data is the word the slave shifts out next frame.
module spi_reg_bridge #(
  parameter int              NBIT     = 8,
  parameter int              NREG     = 8,
  parameter int              TIMEOUT  = 1000000,
  parameter logic [NBIT-1:0] CTRL_RST = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NBIT-1:0]         rx_data,
  input  logic                    rx_strobe,
  input  logic                    tx_strobe,
  output logic [NBIT-1:0]         tx_data,
  input  logic [NREG*NBIT-1:0]    stat_i,
  output logic [NREG*NBIT-1:0]    ctrl_o,
  output logic                    wr_strobe,
  output logic [$clog2(NREG)-1:0] wr_addr
);

  localparam int AW = $clog2(NREG);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   TO_LAST  = CW'(TIMEOUT - 1);
  // Address bounds are compared at full NBIT width so that 2*NREG equal to
  // 2^(NBIT-1) does not wrap to zero.
  localparam logic [NBIT-1:0] CTRL_END = NBIT'(NREG);
  localparam logic [NBIT-1:0] STAT_END = NBIT'(2 * NREG);

  typedef enum logic {IDLE, DATA} state_t;

  state_t          state;
  logic [NBIT-1:0] cmd_reg;
  logic            err_addr;
  logic            err_tout;
  logic            frame_act;
  logic [CW-1:0]   tout_cnt;
  logic [NBIT-1:0] ctrl_reg [NREG];
  logic [NBIT-1:0] stat_w   [NREG];

  logic [NBIT-1:0] rx_addr;
  logic [NBIT-1:0] cmd_addr;
  logic [AW-1:0]   rx_soff;
  logic            rx_is_ctrl;
  logic            rx_is_stat;
  logic            cmd_is_ctrl;
  logic            cmd_is_stat;
  logic [NBIT-1:0] rd_val;
  logic            data_err;

  // Status word: fixed 1010 signature in the top nibble, flags in bits 1:0.
  function automatic logic [NBIT-1:0] status_word(input logic ea, input logic et);
    logic [NBIT-1:0] s;
    s = '0;
    s[NBIT-1 -: 4] = 4'b1010;
    s[1] = ea;
    s[0] = et;
    return s;
  endfunction

  // Unpack status inputs and pack control registers onto the flat buses.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_pack
      assign stat_w[gi]              = stat_i[gi*NBIT +: NBIT];
      assign ctrl_o[gi*NBIT +: NBIT] = ctrl_reg[gi];
    end
  endgenerate

  // Address decode for the incoming command word and for the latched command.
  always_comb begin
    rx_addr     = {1'b0, rx_data[NBIT-2:0]};
    cmd_addr    = {1'b0, cmd_reg[NBIT-2:0]};
    rx_soff     = AW'(rx_addr - CTRL_END);
    rx_is_ctrl  = (rx_addr < CTRL_END);
    rx_is_stat  = !rx_is_ctrl && (rx_addr < STAT_END);
    cmd_is_ctrl = (cmd_addr < CTRL_END);
    cmd_is_stat = !cmd_is_ctrl && (cmd_addr < STAT_END);
    rd_val      = '0;
    if (rx_is_ctrl) begin
      rd_val = ctrl_reg[rx_addr[AW-1:0]];
    end else if (rx_is_stat) begin
      rd_val = stat_w[rx_soff];
    end
    // A write aimed at a status register is flagged when the data arrives.
    data_err = err_addr | (!cmd_reg[NBIT-1] & cmd_is_stat);
  end

  // Command/data FSM with frame tracking, timeout and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_reg   <= '0;
      err_addr  <= 1'b0;
      err_tout  <= 1'b0;
      frame_act <= 1'b0;
      tout_cnt  <= '0;
      tx_data   <= status_word(1'b0, 1'b0);
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      for (int i = 0; i < NREG; i++) begin
        ctrl_reg[i] <= CTRL_RST;
      end
    end else begin
      wr_strobe <= 1'b0;

      // rx_strobe closes a frame, tx_strobe opens one; opening wins a tie.
      if (tx_strobe) begin
        frame_act <= 1'b1;
      end else if (rx_strobe) begin
        frame_act <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rx_strobe) begin
            cmd_reg  <= rx_data;
            state    <= DATA;
            tout_cnt <= '0;
            err_tout <= 1'b0;
            err_addr <= !rx_is_ctrl && !rx_is_stat;
            tx_data  <= rx_data[NBIT-1] ? rd_val : '0;
          end
        end

        DATA: begin
          if (rx_strobe) begin
            state <= IDLE;
            if (!cmd_reg[NBIT-1] && cmd_is_ctrl) begin
              ctrl_reg[cmd_addr[AW-1:0]] <= rx_data;
              wr_strobe <= 1'b1;
              wr_addr   <= cmd_addr[AW-1:0];
            end
            err_addr <= data_err;
            tx_data  <= status_word(data_err, err_tout);
          end else if (frame_act) begin
            tout_cnt <= '0;
          end else if (tout_cnt == TO_LAST) begin
            err_tout <= 1'b1;
            tx_data  <= status_word(err_addr, 1'b1);
            state    <= IDLE;
          end else begin
            tout_cnt <= tout_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: a table of frames with expected
// tx_data / write results, then hand-written multi-cycle sequences.
module tb_spi_reg_bridge;

  localparam int NBIT    = 8;
  localparam int NREG    = 8;
  localparam int TIMEOUT = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NBIT-1:0]      rx_data;
  logic                 rx_strobe;
  logic                 tx_strobe;
  logic [NBIT-1:0]      tx_data;
  logic [NREG*NBIT-1:0] stat_i;
  logic [NREG*NBIT-1:0] ctrl_o;
  logic                 wr_strobe;
  logic [2:0]           wr_addr;

  int n_checks = 0;
  int n_pass   = 0;

  spi_reg_bridge #(
    .NBIT    (NBIT),
    .NREG    (NREG),
    .TIMEOUT (TIMEOUT),
    .CTRL_RST('0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_strobe(rx_strobe),
    .tx_strobe(tx_strobe),
    .tx_data  (tx_data),
    .stat_i   (stat_i),
    .ctrl_o   (ctrl_o),
    .wr_strobe(wr_strobe),
    .wr_addr  (wr_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] tx;
    logic       wr;
    logic [2:0] waddr;
    int         cidx;
    logic [7:0] cval;
  } vec_t;

  vec_t vecs [24];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One rx_strobe pulse; returns at the falling edge after the sampling edge.
  task automatic send_rx(input logic [7:0] w);
    @(negedge clk);
    rx_data   = w;
    rx_strobe = 1'b1;
    @(negedge clk);
    rx_strobe = 1'b0;
  endtask

  // A full frame: start pulse, a couple of bit-times, then the end pulse.
  task automatic frame(input logic [7:0] w);
    @(negedge clk);
    tx_strobe = 1'b1;
    @(negedge clk);
    tx_strobe = 1'b0;
    repeat (2) @(negedge clk);
    send_rx(w);
  endtask

  function automatic logic [7:0] ctrl_word(input int k);
    return ctrl_o[k*8 +: 8];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{8'h00, 8'h00, 1'b0, 3'd0, 0, 8'h00};
    vecs[1]  = '{8'h5A, 8'hA0, 1'b1, 3'd0, 0, 8'h5A};
    vecs[2]  = '{8'h03, 8'h00, 1'b0, 3'd0, 3, 8'h00};
    vecs[3]  = '{8'h3C, 8'hA0, 1'b1, 3'd3, 3, 8'h3C};
    vecs[4]  = '{8'h83, 8'h3C, 1'b0, 3'd0, 3, 8'h3C};
    vecs[5]  = '{8'h99, 8'hA0, 1'b0, 3'd0, 3, 8'h3C};
    vecs[6]  = '{8'h80, 8'h5A, 1'b0, 3'd0, 0, 8'h5A};
    vecs[7]  = '{8'h00, 8'hA0, 1'b0, 3'd0, 0, 8'h5A};
    vecs[8]  = '{8'h07, 8'h00, 1'b0, 3'd0, 7, 8'h00};
    vecs[9]  = '{8'hC3, 8'hA0, 1'b1, 3'd7, 7, 8'hC3};
    vecs[10] = '{8'h8D, 8'h55, 1'b0, 3'd0, 7, 8'hC3};
    vecs[11] = '{8'h12, 8'hA0, 1'b0, 3'd0, 2, 8'h00};
    vecs[12] = '{8'h0C, 8'h00, 1'b0, 3'd0, 4, 8'h00};
    vecs[13] = '{8'hEE, 8'hA2, 1'b0, 3'd0, 4, 8'h00};
    vecs[14] = '{8'h81, 8'h00, 1'b0, 3'd0, 1, 8'h00};
    vecs[15] = '{8'h00, 8'hA0, 1'b0, 3'd0, 1, 8'h00};
    vecs[16] = '{8'h10, 8'h00, 1'b0, 3'd0, 0, 8'h5A};
    vecs[17] = '{8'hFF, 8'hA2, 1'b0, 3'd0, 0, 8'h5A};
    vecs[18] = '{8'h90, 8'h00, 1'b0, 3'd0, 0, 8'h5A};
    vecs[19] = '{8'h00, 8'hA2, 1'b0, 3'd0, 0, 8'h5A};
    vecs[20] = '{8'h8F, 8'h57, 1'b0, 3'd0, 7, 8'hC3};
    vecs[21] = '{8'h00, 8'hA0, 1'b0, 3'd0, 7, 8'hC3};
    vecs[22] = '{8'h87, 8'hC3, 1'b0, 3'd0, 7, 8'hC3};
    vecs[23] = '{8'h00, 8'hA0, 1'b0, 3'd0, 7, 8'hC3};

    rst_n     = 1'b0;
    rx_data   = '0;
    rx_strobe = 1'b0;
    tx_strobe = 1'b0;
    for (int k = 0; k < NREG; k++) begin
      stat_i[k*8 +: 8] = {4'h5, 4'(k)};
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("reset_tx", tx_data, 64'hA0);
    check("reset_ctrl", ctrl_o, 64'h0);
    check("reset_wr", wr_strobe, 64'h0);
    check("reset_waddr", wr_addr, 64'h0);

    for (int i = 0; i < 24; i++) begin
      frame(vecs[i].rx);
      $display("vec %0d rx=0x%02h tx=0x%02h wr=%0d waddr=%0d", i, vecs[i].rx, tx_data, wr_strobe, wr_addr);
      check($sformatf("vec%0d_tx", i), tx_data, 64'(vecs[i].tx));
      check($sformatf("vec%0d_wr", i), wr_strobe, 64'(vecs[i].wr));
      if (vecs[i].wr) begin
        check($sformatf("vec%0d_waddr", i), wr_addr, 64'(vecs[i].waddr));
      end
      check($sformatf("vec%0d_ctrl%0d", i, vecs[i].cidx), ctrl_word(vecs[i].cidx), 64'(vecs[i].cval));
    end

    // Status snapshot taken at the command edge survives later stat_i changes.
    stat_i[2*8 +: 8] = 8'h77;
    frame(8'h8A);
    check("snap_cmd_tx", tx_data, 64'h77);
    stat_i[2*8 +: 8] = 8'h11;
    repeat (5) @(negedge clk);
    check("snap_hold_tx", tx_data, 64'h77);
    frame(8'h00);
    $display("snapshot read tx=0x%02h", tx_data);
    check("snap_data_tx", tx_data, 64'hA0);

    // Timeout: no data frame for TIMEOUT cycles returns to IDLE with err_tout.
    send_rx(8'h01);
    check("tout_cmd_tx", tx_data, 64'h00);
    repeat (TIMEOUT - 1) @(negedge clk);
    check("tout_before_tx", tx_data, 64'h00);
    @(negedge clk);
    $display("timeout tx=0x%02h", tx_data);
    check("tout_expired_tx", tx_data, 64'hA1);
    check("tout_no_write", ctrl_word(1), 64'h00);

    // Next word after a timeout is a fresh command.
    send_rx(8'h02);
    check("post_tout_cmd_tx", tx_data, 64'h00);
    frame(8'h44);
    $display("post-timeout write tx=0x%02h wr=%0d waddr=%0d", tx_data, wr_strobe, wr_addr);
    check("post_tout_wr", wr_strobe, 64'h1);
    check("post_tout_waddr", wr_addr, 64'h2);
    check("post_tout_ctrl2", ctrl_word(2), 64'h44);
    check("post_tout_tx", tx_data, 64'hA0);

    // An open frame suspends the timeout indefinitely.
    send_rx(8'h82);
    check("open_cmd_tx", tx_data, 64'h44);
    repeat (5) @(negedge clk);
    tx_strobe = 1'b1;
    @(negedge clk);
    tx_strobe = 1'b0;
    repeat (3 * TIMEOUT) @(negedge clk);
    check("open_hold_tx", tx_data, 64'h44);
    send_rx(8'h00);
    $display("open-frame read done tx=0x%02h", tx_data);
    check("open_done_tx", tx_data, 64'hA0);

    // rx_strobe on the exact expiry cycle is handled as the data frame.
    send_rx(8'h04);
    repeat (TIMEOUT - 2) @(negedge clk);
    send_rx(8'h66);
    $display("expiry-edge write tx=0x%02h wr=%0d waddr=%0d", tx_data, wr_strobe, wr_addr);
    check("edge_wr", wr_strobe, 64'h1);
    check("edge_waddr", wr_addr, 64'h4);
    check("edge_ctrl4", ctrl_word(4), 64'h66);
    check("edge_tx", tx_data, 64'hA0);

    // Asynchronous reset between command and data frames.
    send_rx(8'h05);
    check("rst_cmd_tx", tx_data, 64'h00);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_async_tx", tx_data, 64'hA0);
    check("rst_async_ctrl", ctrl_o, 64'h0);
    check("rst_async_wr", wr_strobe, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send_rx(8'h86);
    $display("post-reset frame tx=0x%02h", tx_data);
    check("rst_next_is_cmd_tx", tx_data, 64'h00);
    send_rx(8'h00);
    check("rst_next_data_tx", tx_data, 64'hA0);
    check("rst_next_ctrl", ctrl_o, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
